// File: rtl/enigma_stepper_if.sv
// Key-input and rotor-chain output channels of the Enigma stepper.
// The master side offers key codes and consumes letters and positions.
interface enigma_stepper_if;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_ready;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_letter;
    logic [4:0]  pos_l;
    logic [4:0]  pos_m;
    logic [4:0]  pos_r;

    modport master (
        output key_valid, key_code, out_ready,
        input  key_ready, out_valid, out_letter, pos_l, pos_m, pos_r
    );

    modport slave (
        input  key_valid, key_code, out_ready,
        output key_ready, out_valid, out_letter, pos_l, pos_m, pos_r
    );
endinterface

// File: rtl/enigma_stepper.sv
// Enigma rotor position controller: odometer stepping with the middle-rotor
// double-step, and a one-entry output register feeding the rotor chain.
module enigma_stepper #(
    parameter logic [4:0] NOTCH_R = 5'd21,
    parameter logic [4:0] NOTCH_M = 5'd4,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [4:0]       load_pos_l,
    input  logic [4:0]       load_pos_m,
    input  logic [4:0]       load_pos_r,
    enigma_stepper_if.slave  kif,
    output logic             key_err,
    output logic [CNT_W-1:0] key_count
);
    localparam logic [4:0] LAST_POS = 5'd25;

    logic [4:0]  pos_l, pos_m, pos_r;
    logic        out_valid;
    logic [25:0] out_letter;
    logic        key_ready;
    logic        accept;
    logic        code_ok;
    logic        step_l;
    logic        step_m;

    function automatic logic [4:0] advance(input logic [4:0] p);
        return (p >= LAST_POS) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [4:0] sanitize(input logic [4:0] p);
        return (p > LAST_POS) ? 5'd0 : p;
    endfunction

    // NOTE: every signal is assigned on every pass, so no latch can be inferred.
    always_comb begin
        key_ready = !load && (!out_valid || kif.out_ready);
        accept    = kif.key_valid && key_ready;
        code_ok   = kif.key_code <= LAST_POS;
        // Middle rotor at its notch steps itself and the left rotor (double-step).
        step_l    = (pos_m == NOTCH_M);
        step_m    = (pos_r == NOTCH_R) || step_l;
    end

    // NOTE: non-blocking assignments so all stepping tests see pre-step positions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_l      <= 5'd0;
            pos_m      <= 5'd0;
            pos_r      <= 5'd0;
            out_valid  <= 1'b0;
            out_letter <= '0;
            key_count  <= '0;
            key_err    <= 1'b0;
        end else if (load) begin
            pos_l      <= sanitize(load_pos_l);
            pos_m      <= sanitize(load_pos_m);
            pos_r      <= sanitize(load_pos_r);
            out_valid  <= 1'b0;
            out_letter <= '0;
            key_count  <= '0;
            key_err    <= 1'b0;
        end else begin
            key_err <= accept && !code_ok;
            if (accept && code_ok) begin
                if (step_l) pos_l <= advance(pos_l);
                if (step_m) pos_m <= advance(pos_m);
                pos_r      <= advance(pos_r);
                out_letter <= 26'd1 << kif.key_code;
                out_valid  <= 1'b1;
                key_count  <= key_count + CNT_W'(1);
            end else if (out_valid && kif.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign kif.key_ready  = key_ready;
    assign kif.out_valid  = out_valid;
    assign kif.out_letter = out_letter;
    assign kif.pos_l      = pos_l;
    assign kif.pos_m      = pos_m;
    assign kif.pos_r      = pos_r;
endmodule

// File: tb/tb_enigma_stepper.sv
// Scoreboard bench for enigma_stepper: a driver pushes expected outputs from an
// arithmetic rotor model, a monitor compares whatever the DUT presents.
module tb_enigma_stepper;
    localparam int NOTCH_R = 21;
    localparam int NOTCH_M = 4;
    localparam int CNT_W   = 16;

    typedef struct {
        logic [25:0] letter;
        int          l;
        int          m;
        int          r;
        int          count;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic [4:0]       load_pos_l = '0;
    logic [4:0]       load_pos_m = '0;
    logic [4:0]       load_pos_r = '0;
    logic             key_err;
    logic [CNT_W-1:0] key_count;

    enigma_stepper_if kif();

    enigma_stepper #(
        .NOTCH_R(5'd21),
        .NOTCH_M(5'd4),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_pos_l(load_pos_l),
        .load_pos_m(load_pos_m),
        .load_pos_r(load_pos_r),
        .kif       (kif),
        .key_err   (key_err),
        .key_count (key_count)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   ml = 0, mm = 0, mr = 0, mcount = 0;
    bit   err_next = 1'b0;
    bit   err_exp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a key advances the machine like a mechanical odometer.
    task automatic model_key(input int code);
        exp_t e;
        bit   dl, dm;
        if (code > 25) begin
            err_next = 1'b1;
            return;
        end
        dl = (mm == NOTCH_M);
        dm = (mr == NOTCH_R) || dl;
        ml = (ml + int'(dl)) % 26;
        mm = (mm + int'(dm)) % 26;
        mr = (mr + 1) % 26;
        mcount = (mcount + 1) % (1 << CNT_W);
        e.letter = '0;
        e.letter[code] = 1'b1;
        e.l = ml;
        e.m = mm;
        e.r = mr;
        e.count = mcount;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_key(input int code, input bit rand_ready);
        int waited = 0;
        bit done = 1'b0;
        kif.key_valid = 1'b1;
        kif.key_code  = 5'(code);
        while (!done) begin
            @(negedge clk);
            if (kif.key_ready) begin
                model_key(code);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (rand_ready) kif.out_ready = ($urandom_range(0, 3) != 0);
                if (waited > 50) begin
                    check("accept_timeout", 64'd0, 64'd1);
                    done = 1'b1;
                end
            end
        end
        kif.key_valid = 1'b0;
    endtask

    task automatic do_load(input int l, input int m, input int r);
        load       = 1'b1;
        load_pos_l = 5'(l);
        load_pos_m = 5'(m);
        load_pos_r = 5'(r);
        sb.delete();
        ml = (l > 25) ? 0 : l;
        mm = (m > 25) ? 0 : m;
        mr = (r > 25) ? 0 : r;
        mcount = 0;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", kif.out_valid, 0);
        check("rst_out_letter", kif.out_letter, 0);
        check("rst_pos", {kif.pos_l, kif.pos_m, kif.pos_r}, 0);
        check("rst_key_count", key_count, 0);
        check("rst_key_err", key_err, 0);
        sb.delete();
        ml = 0; mm = 0; mr = 0; mcount = 0;
        err_next = 1'b0;
        err_exp  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", kif.key_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares key_err each cycle and any presented output to the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) continue;
            check("key_err", key_err, err_exp);
            err_exp  = err_next;
            err_next = 1'b0;
            if (kif.out_valid && !load) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = sb[0];
                    check("out_letter", kif.out_letter, e.letter);
                    check("pos_l", kif.pos_l, e.l);
                    check("pos_m", kif.pos_m, e.m);
                    check("pos_r", kif.pos_r, e.r);
                    check("key_count", key_count, e.count);
                    if (kif.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   saved_count;
        int   r;
        logic [25:0] lz;

        kif.key_valid = 1'b0;
        kif.key_code  = '0;
        kif.out_ready = 1'b1;

        // Reset/idle
        #12;
        check("init_out_valid", kif.out_valid, 0);
        check("init_pos", {kif.pos_l, kif.pos_m, kif.pos_r}, 0);
        check("init_key_count", key_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("init_key_ready", kif.key_ready, 1);
        @(posedge clk);
        #1;

        // Double-step: ADU -> ADV -> AEW -> BFX
        do_load(0, 3, 20);
        send_key(0, 0);
        check("ds1_pos", {kif.pos_l, kif.pos_m, kif.pos_r}, {5'd0, 5'd3, 5'd21});
        send_key(0, 0);
        check("ds2_pos", {kif.pos_l, kif.pos_m, kif.pos_r}, {5'd0, 5'd4, 5'd22});
        send_key(0, 0);
        check("ds3_pos", {kif.pos_l, kif.pos_m, kif.pos_r}, {5'd1, 5'd5, 5'd23});
        check("ds_letter", kif.out_letter, 26'h1);
        check("ds_count", key_count, 3);

        // Wrap-around
        do_load(25, 25, 25);
        send_key(25, 0);
        check("wrap_pos", {kif.pos_l, kif.pos_m, kif.pos_r}, {5'd25, 5'd25, 5'd0});
        lz = kif.out_letter;
        check("wrap_letter_z", lz[25], 1);
        @(posedge clk);
        #1;

        // Backpressure
        kif.out_ready = 1'b0;
        send_key(2, 0);
        @(negedge clk);
        check("bp_out_valid", kif.out_valid, 1);
        check("bp_key_ready", kif.key_ready, 0);
        kif.key_valid = 1'b1;
        kif.key_code  = 5'd3;
        repeat (3) begin
            @(negedge clk);
            check("bp_frozen_pos", {kif.pos_l, kif.pos_m, kif.pos_r}, {5'(ml), 5'(mm), 5'(mr)});
            check("bp_blocked", kif.key_ready, 0);
        end
        @(posedge clk);
        #1;
        kif.out_ready = 1'b1;
        send_key(3, 0);
        check("bp_b2b_valid", kif.out_valid, 1);

        // Invalid code
        @(posedge clk);
        #1;
        saved_count = mcount;
        send_key(27, 0);
        check("inv_err_high", key_err, 1);
        check("inv_out_valid", kif.out_valid, 0);
        check("inv_count", key_count, saved_count);
        check("inv_pos", {kif.pos_l, kif.pos_m, kif.pos_r}, {5'(ml), 5'(mm), 5'(mr)});
        @(posedge clk);
        #1;
        check("inv_err_low", key_err, 0);

        // Load collision
        kif.out_ready = 1'b0;
        send_key(7, 0);
        kif.key_valid = 1'b1;
        kif.key_code  = 5'd8;
        do_load(2, 2, 2);
        kif.key_valid = 1'b0;
        check("ld_pos", {kif.pos_l, kif.pos_m, kif.pos_r}, {5'd2, 5'd2, 5'd2});
        check("ld_out_valid", kif.out_valid, 0);
        check("ld_count", key_count, 0);

        // Out-of-range load values
        do_load(30, 26, 31);
        check("ld_sanitize", {kif.pos_l, kif.pos_m, kif.pos_r}, 0);
        kif.out_ready = 1'b1;

        // Randomized stream with occasional loads and mid-stream resets
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_load($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            end else if (r < 5) begin
                rst_pulse();
            end else if (r < 15) begin
                kif.out_ready = ($urandom_range(0, 1) != 0);
                @(posedge clk);
                #1;
            end else begin
                kif.out_ready = ($urandom_range(0, 3) != 0);
                send_key((r < 23) ? $urandom_range(26, 31) : $urandom_range(0, 25), 1);
            end
        end

        kif.out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
